// File: rtl/poly_beeper.sv
// rtl/poly_beeper.sv - keypad-to-buzzer square-wave tone generator with octave, volume and pluck decay
// Period and duty are latched only at period boundaries so the output never emits a runt pulse.
module poly_beeper #(
    parameter int                            NUM_KEYS          = 16,
    parameter int                            CNT_WIDTH         = 20,
    parameter logic [NUM_KEYS*CNT_WIDTH-1:0] CYCLE_TABLE       = '0,
    parameter int                            DECAY_STEP_CYCLES = 2500000,
    parameter int                            DECAY_LEVELS      = 8
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [NUM_KEYS-1:0]         key_in,
    input  logic [1:0]                  octave,
    input  logic [2:0]                  volume,
    input  logic                        mode,
    output logic                        beeper,
    output logic                        note_active,
    output logic [$clog2(NUM_KEYS)-1:0] cur_key
);

    localparam int KW = $clog2(NUM_KEYS);
    localparam int TW = $clog2(DECAY_STEP_CYCLES + 1);

    logic [NUM_KEYS-1:0]  key_q, key_d;
    logic                 beeper_q, beeper_d;
    logic                 active_q, active_d;
    logic [KW-1:0]        cur_key_q, cur_key_d;
    logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
    logic [CNT_WIDTH-1:0] cur_cycle_q, cur_cycle_d;
    logic [CNT_WIDTH-1:0] cur_duty_q, cur_duty_d;
    logic [3:0]           lvl_q, lvl_d;
    logic [TW-1:0]        timer_q, timer_d;

    logic [KW-1:0]        sel;
    logic                 valid;
    logic [CNT_WIDTH-1:0] tgt_raw, tgt_shift, tgt, duty;
    logic [3:0]           eff_lvl;
    logic [4:0]           sh;
    logic                 silent;
    logic                 boundary, key_moved, timer_wrap;

    // Lowest-index pressed key wins.
    always_comb begin
        sel = '0;
        for (int i = NUM_KEYS - 1; i >= 0; i--) begin
            if (key_q[i]) sel = KW'(i);
        end
    end

    always_comb begin
        valid      = |key_q;
        tgt_raw    = CYCLE_TABLE[int'(sel)*CNT_WIDTH +: CNT_WIDTH];
        tgt_shift  = tgt_raw >> octave;
        tgt        = (tgt_shift < CNT_WIDTH'(2)) ? CNT_WIDTH'(2) : tgt_shift;
        eff_lvl    = mode ? lvl_q : 4'd0;
        sh         = 5'(3'd7 - volume) + 5'd1 + 5'(eff_lvl);
        silent     = (volume == 3'd0) || (int'(eff_lvl) >= DECAY_LEVELS);
        duty       = (silent || int'(sh) >= CNT_WIDTH) ? '0 : (tgt >> sh);
        boundary   = (cnt_q == cur_cycle_q - CNT_WIDTH'(1));
        key_moved  = (sel != cur_key_q);
        timer_wrap = (timer_q == TW'(DECAY_STEP_CYCLES - 1));
    end

    always_comb begin
        key_d       = key_in;
        beeper_d    = beeper_q;
        active_d    = active_q;
        cur_key_d   = cur_key_q;
        cnt_d       = cnt_q;
        cur_cycle_d = cur_cycle_q;
        cur_duty_d  = cur_duty_q;
        lvl_d       = lvl_q;
        timer_d     = timer_q;
        if (!valid) begin
            beeper_d = 1'b0;
            active_d = 1'b0;
            cnt_d    = '0;
            lvl_d    = '0;
            timer_d  = '0;
        end else if (!active_q) begin
            cur_cycle_d = tgt;
            cur_duty_d  = duty;
            cnt_d       = '0;
            cur_key_d   = sel;
            active_d    = 1'b1;
            lvl_d       = '0;
            timer_d     = '0;
        end else begin
            beeper_d = (cnt_q < cur_duty_q);
            if (boundary) begin
                cnt_d       = '0;
                cur_cycle_d = tgt;
                cur_duty_d  = duty;
                cur_key_d   = sel;
            end else begin
                cnt_d = cnt_q + CNT_WIDTH'(1);
            end
            // A new key in decay mode replucks the string.
            if (!mode || (boundary && key_moved)) begin
                lvl_d   = '0;
                timer_d = '0;
            end else if (timer_wrap) begin
                timer_d = '0;
                if (int'(lvl_q) < DECAY_LEVELS) lvl_d = lvl_q + 4'd1;
            end else begin
                timer_d = timer_q + TW'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            key_q       <= '0;
            beeper_q    <= 1'b0;
            active_q    <= 1'b0;
            cur_key_q   <= '0;
            cnt_q       <= '0;
            cur_cycle_q <= '0;
            cur_duty_q  <= '0;
            lvl_q       <= '0;
            timer_q     <= '0;
        end else begin
            key_q       <= key_d;
            beeper_q    <= beeper_d;
            active_q    <= active_d;
            cur_key_q   <= cur_key_d;
            cnt_q       <= cnt_d;
            cur_cycle_q <= cur_cycle_d;
            cur_duty_q  <= cur_duty_d;
            lvl_q       <= lvl_d;
            timer_q     <= timer_d;
        end
    end

    assign beeper      = beeper_q;
    assign note_active = active_q;
    assign cur_key     = cur_key_q;

endmodule

// File: tb/tb_poly_beeper.sv
// tb/tb_poly_beeper.sv - directed self-checking bench for poly_beeper
// Inputs change on the falling edge; outputs are read on the falling edge.
module tb_poly_beeper;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] key_in, key_in2;
    logic [1:0] octave;
    logic [2:0] volume;
    logic       mode;
    logic       beeper, note_active, beeper2, note_active2;
    logic [1:0] cur_key, cur_key2;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    poly_beeper #(
        .NUM_KEYS(4), .CNT_WIDTH(8),
        .CYCLE_TABLE({8'd40, 8'd30, 8'd20, 8'd10}),
        .DECAY_STEP_CYCLES(100), .DECAY_LEVELS(3)
    ) dut (
        .clk(clk), .rst(rst), .key_in(key_in), .octave(octave), .volume(volume),
        .mode(mode), .beeper(beeper), .note_active(note_active), .cur_key(cur_key)
    );

    // Rebuild with tiny table entries to exercise the minimum-period clamp.
    poly_beeper #(
        .NUM_KEYS(4), .CNT_WIDTH(8),
        .CYCLE_TABLE({8'd40, 8'd30, 8'd3, 8'd1}),
        .DECAY_STEP_CYCLES(100), .DECAY_LEVELS(3)
    ) dut_clamp (
        .clk(clk), .rst(rst), .key_in(key_in2), .octave(octave), .volume(volume),
        .mode(mode), .beeper(beeper2), .note_active(note_active2), .cur_key(cur_key2)
    );

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic measure(input int n, output int hi);
        hi = 0;
        for (int i = 0; i < n; i++) begin
            if (beeper) hi++;
            step();
        end
    endtask

    task automatic do_reset();
        rst = 1'b1; key_in = '0; key_in2 = '0;
        octave = 2'd0; volume = 3'd7; mode = 1'b0;
        step();
        rst = 1'b0;
        step();
    endtask

    task automatic test_reset();
        rst = 1'b1; key_in = 4'b1111; key_in2 = 4'b1111;
        octave = 2'd0; volume = 3'd7; mode = 1'b0;
        step(); step(); step();
        checks++; if (beeper !== 1'b0) begin errors++; $display("FAIL reset_beeper got %0b want 0", beeper); end
        checks++; if (note_active !== 1'b0) begin errors++; $display("FAIL reset_active got %0b want 0", note_active); end
        checks++; if (cur_key !== 2'd0) begin errors++; $display("FAIL reset_cur_key got %0d want 0", cur_key); end
        rst = 1'b0; key_in = '0; key_in2 = '0;
        step(); step();
    endtask

    task automatic test_basic_tone();
        int hi;
        do_reset();
        key_in = 4'b0001;
        step();
        checks++; if (note_active !== 1'b0 || beeper !== 1'b0) begin errors++; $display("FAIL basic_edge1 got active=%0b beep=%0b want 0 0", note_active, beeper); end
        step();
        checks++; if (note_active !== 1'b1 || beeper !== 1'b0) begin errors++; $display("FAIL basic_edge2 got active=%0b beep=%0b want 1 0", note_active, beeper); end
        checks++; if (cur_key !== 2'd0) begin errors++; $display("FAIL basic_cur_key got %0d want 0", cur_key); end
        step();
        checks++; if (beeper !== 1'b1) begin errors++; $display("FAIL basic_first_rise got %0b want 1", beeper); end
        for (int p = 0; p < 3; p++) begin
            measure(10, hi);
            checks++; if (hi !== 5) begin errors++; $display("FAIL basic_high_p%0d got %0d want 5", p, hi); end
        end
    endtask

    task automatic test_key_change();
        int hi;
        do_reset();
        key_in = 4'b0001;
        step(); step(); step();
        step(); step();
        key_in = 4'b0010;
        measure(6, hi);
        checks++; if (hi !== 3) begin errors++; $display("FAIL kc_old_tail got %0d want 3", hi); end
        checks++; if (cur_key !== 2'd0) begin errors++; $display("FAIL kc_key_before got %0d want 0", cur_key); end
        step();
        checks++; if (cur_key !== 2'd1) begin errors++; $display("FAIL kc_key_at_boundary got %0d want 1", cur_key); end
        checks++; if (beeper !== 1'b0) begin errors++; $display("FAIL kc_old_last got %0b want 0", beeper); end
        step();
        for (int p = 0; p < 2; p++) begin
            measure(20, hi);
            checks++; if (hi !== 10) begin errors++; $display("FAIL kc_new_p%0d got %0d want 10", p, hi); end
        end
    endtask

    task automatic test_octave_volume();
        int hi;
        do_reset();
        octave = 2'd1;
        key_in = 4'b1000;
        step(); step(); step();
        checks++; if (cur_key !== 2'd3) begin errors++; $display("FAIL ov_cur_key got %0d want 3", cur_key); end
        measure(20, hi);
        checks++; if (hi !== 10) begin errors++; $display("FAIL ov_oct1 got %0d want 10", hi); end
        volume = 3'd6;
        measure(20, hi);
        checks++; if (hi !== 10) begin errors++; $display("FAIL ov_vol6_pending got %0d want 10", hi); end
        measure(20, hi);
        checks++; if (hi !== 5) begin errors++; $display("FAIL ov_vol6 got %0d want 5", hi); end
        volume = 3'd0;
        measure(20, hi);
        checks++; if (hi !== 5) begin errors++; $display("FAIL ov_vol0_pending got %0d want 5", hi); end
        measure(20, hi);
        checks++; if (hi !== 0) begin errors++; $display("FAIL ov_vol0 got %0d want 0", hi); end
        checks++; if (note_active !== 1'b1) begin errors++; $display("FAIL ov_vol0_active got %0b want 1", note_active); end
    endtask

    task automatic test_decay();
        int hi;
        int exp_hi;
        do_reset();
        mode = 1'b1;
        key_in = 4'b0010;
        step(); step(); step();
        // Envelope steps at 100/200/300 clocks; each period uses the level held at its start.
        for (int k = 0; k < 20; k++) begin
            exp_hi = (k <= 5) ? 10 : (k <= 10) ? 5 : (k <= 15) ? 2 : 0;
            measure(20, hi);
            checks++; if (hi !== exp_hi) begin errors++; $display("FAIL decay_p%0d got %0d want %0d", k, hi, exp_hi); end
        end
        checks++; if (note_active !== 1'b1) begin errors++; $display("FAIL decay_silent_active got %0b want 1", note_active); end
        key_in = 4'b0000;
        step();
        key_in = 4'b0010;
        step();
        checks++; if (note_active !== 1'b0 || beeper !== 1'b0) begin errors++; $display("FAIL decay_release got active=%0b beep=%0b want 0 0", note_active, beeper); end
        step(); step();
        checks++; if (beeper !== 1'b1) begin errors++; $display("FAIL decay_repress_rise got %0b want 1", beeper); end
        measure(20, hi);
        checks++; if (hi !== 10) begin errors++; $display("FAIL decay_repress got %0d want 10", hi); end
        mode = 1'b0;
    endtask

    task automatic test_priority_release();
        int hi;
        do_reset();
        key_in = 4'b0110;
        step(); step(); step();
        checks++; if (cur_key !== 2'd1) begin errors++; $display("FAIL prio_cur_key got %0d want 1", cur_key); end
        measure(20, hi);
        checks++; if (hi !== 10) begin errors++; $display("FAIL prio_high got %0d want 10", hi); end
        key_in = 4'b0000;
        step(); step();
        checks++; if (beeper !== 1'b0 || note_active !== 1'b0) begin errors++; $display("FAIL rel_outputs got beep=%0b active=%0b want 0 0", beeper, note_active); end
        checks++; if (cur_key !== 2'd1) begin errors++; $display("FAIL rel_cur_key got %0d want 1", cur_key); end
    endtask

    task automatic test_reset_mid_note();
        int hi;
        do_reset();
        key_in = 4'b0001;
        step(); step(); step();
        step(); step();
        checks++; if (beeper !== 1'b1) begin errors++; $display("FAIL rmid_pre_high got %0b want 1", beeper); end
        rst = 1'b1;
        step();
        checks++; if (beeper !== 1'b0 || note_active !== 1'b0 || cur_key !== 2'd0) begin errors++; $display("FAIL rmid_clear got beep=%0b active=%0b key=%0d want 0 0 0", beeper, note_active, cur_key); end
        rst = 1'b0;
        step();
        checks++; if (beeper !== 1'b0 || note_active !== 1'b0) begin errors++; $display("FAIL rmid_edge1 got beep=%0b active=%0b want 0 0", beeper, note_active); end
        step();
        checks++; if (beeper !== 1'b0 || note_active !== 1'b1) begin errors++; $display("FAIL rmid_edge2 got beep=%0b active=%0b want 0 1", beeper, note_active); end
        step();
        checks++; if (beeper !== 1'b1) begin errors++; $display("FAIL rmid_rise got %0b want 1", beeper); end
        measure(10, hi);
        checks++; if (hi !== 5) begin errors++; $display("FAIL rmid_period got %0d want 5", hi); end
    endtask

    task automatic test_clamp();
        int hi;
        do_reset();
        key_in2 = 4'b0001;
        step(); step(); step();
        checks++; if (beeper2 !== 1'b1) begin errors++; $display("FAIL clamp_rise got %0b want 1", beeper2); end
        step();
        checks++; if (beeper2 !== 1'b0) begin errors++; $display("FAIL clamp_fall got %0b want 0", beeper2); end
        hi = 0;
        for (int i = 0; i < 10; i++) begin
            if (beeper2) hi++;
            step();
        end
        checks++; if (hi !== 5) begin errors++; $display("FAIL clamp_key0 got %0d want 5", hi); end
        octave = 2'd1;
        key_in2 = 4'b0010;
        step(); step(); step(); step();
        checks++; if (cur_key2 !== 2'd1) begin errors++; $display("FAIL clamp_cur_key got %0d want 1", cur_key2); end
        hi = 0;
        for (int i = 0; i < 10; i++) begin
            if (beeper2) hi++;
            step();
        end
        checks++; if (hi !== 5) begin errors++; $display("FAIL clamp_key1_oct1 got %0d want 5", hi); end
        checks++; if (note_active2 !== 1'b1) begin errors++; $display("FAIL clamp_active got %0b want 1", note_active2); end
    endtask

    initial begin
        rst = 1'b1; key_in = '0; key_in2 = '0;
        octave = 2'd0; volume = 3'd7; mode = 1'b0;
        test_reset();
        test_basic_tone();
        test_key_change();
        test_octave_volume();
        test_decay();
        test_priority_release();
        test_reset_mid_note();
        test_clamp();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
